// File: rtl/sw_array_driver.sv
// Host-side job sequencer for the 64-PE Smith-Waterman systolic array: clear, query load + pad,
// target stream, drain, then result handshake. Optional macro SW_DRV_TGAP_ERR_EN flags target gaps.
module sw_array_driver #(
    parameter int unsigned NUM_PE       = 64,
    parameter int unsigned DRAIN_CYCLES = 130
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        q_valid,
    output logic        q_ready,
    input  logic [1:0]  q_sym,
    input  logic        q_last,

    input  logic        t_valid,
    output logic        t_ready,
    input  logic [1:0]  t_sym,
    input  logic        t_last,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_score,
    output logic [7:0]  res_qlen,
    output logic [15:0] res_tlen,
    output logic [1:0]  res_err,

    output logic        arr_rst,
    output logic        arr_S_load,
    output logic        arr_S_valid,
    output logic [1:0]  arr_S,
    output logic        arr_ripple_en,
    output logic [1:0]  arr_T,
    output logic [15:0] arr_max_in,
    output logic [15:0] arr_V_in,
    output logic [15:0] arr_V_alpha,
    output logic [15:0] arr_F_in,
    input  logic [15:0] arr_max_out
);

    localparam int unsigned QCNT_W  = 8;
    localparam int unsigned TCNT_W  = 16;
    localparam int unsigned DCNT_W  = 16;
    localparam int unsigned SCORE_W = 16;

    localparam logic [QCNT_W-1:0] PE_LAST   = QCNT_W'(NUM_PE - 1);
    localparam logic [DCNT_W-1:0] DRN_LAST  = DCNT_W'(DRAIN_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_SAT  = {TCNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD_Q, Q_FLUSH, PAD, STREAM_T, DRAIN, RESULT
    } state_t;

    state_t              state, state_n;
    logic [QCNT_W-1:0]   qcnt, qcnt_n;
    logic [QCNT_W-1:0]   shcnt, shcnt_n;
    logic [TCNT_W-1:0]   tcnt, tcnt_n;
    logic [DCNT_W-1:0]   dcnt, dcnt_n;
    logic                qovf, qovf_n;
`ifdef SW_DRV_TGAP_ERR_EN
    logic                t_seen, t_seen_n;
    logic                tgap, tgap_n;
`endif

    logic                res_valid_n;
    logic [SCORE_W-1:0]  res_score_n;
    logic [QCNT_W-1:0]   res_qlen_n;
    logic [TCNT_W-1:0]   res_tlen_n;
    logic [1:0]          res_err_n;

    // The array's score/value injection ports are unused by this host.
    assign arr_max_in  = '0;
    assign arr_V_in    = '0;
    assign arr_V_alpha = '0;
    assign arr_F_in    = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            qcnt      <= '0;
            shcnt     <= '0;
            tcnt      <= '0;
            dcnt      <= '0;
            qovf      <= 1'b0;
`ifdef SW_DRV_TGAP_ERR_EN
            t_seen    <= 1'b0;
            tgap      <= 1'b0;
`endif
            res_valid <= 1'b0;
            res_score <= '0;
            res_qlen  <= '0;
            res_tlen  <= '0;
            res_err   <= '0;
        end else begin
            state     <= state_n;
            qcnt      <= qcnt_n;
            shcnt     <= shcnt_n;
            tcnt      <= tcnt_n;
            dcnt      <= dcnt_n;
            qovf      <= qovf_n;
`ifdef SW_DRV_TGAP_ERR_EN
            t_seen    <= t_seen_n;
            tgap      <= tgap_n;
`endif
            res_valid <= res_valid_n;
            res_score <= res_score_n;
            res_qlen  <= res_qlen_n;
            res_tlen  <= res_tlen_n;
            res_err   <= res_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        qcnt_n        = qcnt;
        shcnt_n       = shcnt;
        tcnt_n        = tcnt;
        dcnt_n        = dcnt;
        qovf_n        = qovf;
`ifdef SW_DRV_TGAP_ERR_EN
        t_seen_n      = t_seen;
        tgap_n        = tgap;
`endif
        res_valid_n   = res_valid;
        res_score_n   = res_score;
        res_qlen_n    = res_qlen;
        res_tlen_n    = res_tlen;
        res_err_n     = res_err;

        q_ready       = 1'b0;
        t_ready       = 1'b0;
        arr_rst       = rst;
        arr_S_load    = 1'b0;
        arr_S_valid   = 1'b0;
        arr_S         = 2'b00;
        arr_ripple_en = 1'b0;
        arr_T         = 2'b00;

        case (state)
            IDLE: begin
                if (q_valid) state_n = CLEAR;
            end

            CLEAR: begin
                arr_rst  = 1'b1;
                qcnt_n   = '0;
                shcnt_n  = '0;
                tcnt_n   = '0;
                dcnt_n   = '0;
                qovf_n   = 1'b0;
`ifdef SW_DRV_TGAP_ERR_EN
                t_seen_n = 1'b0;
                tgap_n   = 1'b0;
`endif
                state_n  = LOAD_Q;
            end

            LOAD_Q: begin
                q_ready = 1'b1;
                if (q_valid) begin
                    arr_S_load  = 1'b1;
                    arr_S_valid = 1'b1;
                    arr_S       = q_sym;
                    qcnt_n      = qcnt + QCNT_W'(1);
                    shcnt_n     = shcnt + QCNT_W'(1);
                    // A full array without q_last means the rest of the query is dropped.
                    if (qcnt == PE_LAST) begin
                        if (q_last) begin
                            state_n = STREAM_T;
                        end else begin
                            qovf_n  = 1'b1;
                            state_n = Q_FLUSH;
                        end
                    end else if (q_last) begin
                        state_n = PAD;
                    end
                end
            end

            Q_FLUSH: begin
                q_ready = 1'b1;
                if (q_valid && q_last) state_n = STREAM_T;
            end

            PAD: begin
                arr_S_load = 1'b1;
                shcnt_n    = shcnt + QCNT_W'(1);
                if (shcnt == PE_LAST) state_n = STREAM_T;
            end

            STREAM_T: begin
                t_ready = 1'b1;
                if (t_valid) begin
                    arr_ripple_en = 1'b1;
                    arr_T         = t_sym;
                    tcnt_n        = (tcnt == TCNT_SAT) ? tcnt : tcnt + TCNT_W'(1);
`ifdef SW_DRV_TGAP_ERR_EN
                    t_seen_n      = 1'b1;
`endif
                    if (t_last) state_n = DRAIN;
                end else begin
`ifdef SW_DRV_TGAP_ERR_EN
                    if (t_seen) tgap_n = 1'b1;
`endif
                end
            end

            DRAIN: begin
                if (dcnt == DRN_LAST) begin
                    state_n     = RESULT;
                    res_valid_n = 1'b1;
                    res_score_n = arr_max_out;
                    res_qlen_n  = qcnt;
                    res_tlen_n  = tcnt;
`ifdef SW_DRV_TGAP_ERR_EN
                    res_err_n   = {tgap, qovf};
`else
                    res_err_n   = {1'b0, qovf};
`endif
                end else begin
                    dcnt_n = dcnt + DCNT_W'(1);
                end
            end

            RESULT: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase

        // Hold the array quiet and refuse beats for as long as reset is asserted.
        if (rst) begin
            q_ready       = 1'b0;
            t_ready       = 1'b0;
            arr_S_load    = 1'b0;
            arr_S_valid   = 1'b0;
            arr_S         = 2'b00;
            arr_ripple_en = 1'b0;
            arr_T         = 2'b00;
        end
    end

endmodule

// File: tb/tb_sw_array_driver.sv
// Bench for sw_array_driver: an array stand-in scores what it sees on arr_*; results are checked
// against a Smith-Waterman reference computed from the generated query/target.
module tb_sw_array_driver;

    localparam int NUM_PE       = 64;
    localparam int DRAIN_CYCLES = 130;
    localparam int MATCH        = 6;
    localparam int MISMATCH     = -3;
    localparam int GAP          = -4;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_valid, q_ready, q_last;
    logic [1:0]  q_sym;
    logic        t_valid, t_ready, t_last;
    logic [1:0]  t_sym;
    logic        res_valid, res_ready;
    logic [15:0] res_score, res_tlen;
    logic [7:0]  res_qlen;
    logic [1:0]  res_err;
    logic        arr_rst, arr_S_load, arr_S_valid, arr_ripple_en;
    logic [1:0]  arr_S, arr_T;
    logic [15:0] arr_max_in, arr_V_in, arr_V_alpha, arr_F_in, arr_max_out;

    always #5 clk = ~clk;

    sw_array_driver #(.NUM_PE(NUM_PE), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .q_valid(q_valid), .q_ready(q_ready), .q_sym(q_sym), .q_last(q_last),
        .t_valid(t_valid), .t_ready(t_ready), .t_sym(t_sym), .t_last(t_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score),
        .res_qlen(res_qlen), .res_tlen(res_tlen), .res_err(res_err),
        .arr_rst(arr_rst), .arr_S_load(arr_S_load), .arr_S_valid(arr_S_valid), .arr_S(arr_S),
        .arr_ripple_en(arr_ripple_en), .arr_T(arr_T),
        .arr_max_in(arr_max_in), .arr_V_in(arr_V_in), .arr_V_alpha(arr_V_alpha),
        .arr_F_in(arr_F_in), .arr_max_out(arr_max_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Linear-gap local alignment score, best cell over the whole matrix.
    function automatic int sw_score(input int a[$], input int b[$]);
        int hp[], hc[];
        int best, diag, v;
        best = 0;
        hp = new[a.size() + 1];
        hc = new[a.size() + 1];
        foreach (hp[i]) hp[i] = 0;
        foreach (b[j]) begin
            hc[0] = 0;
            for (int i = 1; i <= a.size(); i++) begin
                diag = hp[i-1] + ((a[i-1] == b[j]) ? MATCH : MISMATCH);
                v = 0;
                if (diag > v) v = diag;
                if (hp[i] + GAP > v) v = hp[i] + GAP;
                if (hc[i-1] + GAP > v) v = hc[i-1] + GAP;
                hc[i] = v;
                if (v > best) best = v;
            end
            foreach (hp[i]) hp[i] = hc[i];
        end
        return best;
    endfunction

    // Array stand-in and protocol monitor; only this block writes mon_* and arr_max_out.
    int mon_cyc = 0, mon_sload = 0, mon_svalid = 0, mon_clear = 0, mon_viol = 0;
    int mon_qacc = 0, mon_tacc = 0, mon_tlast_cyc = 0, mon_res_cyc = 0;

    initial begin
        int sreg_v[$], sreg_s[$], tq[$], qv[$];
        bit dirty, prev_rv;
        arr_max_out = '0;
        prev_rv = 1'b0;
        dirty = 1'b0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (arr_rst) begin
                sreg_v.delete(); sreg_s.delete(); tq.delete();
                dirty = 1'b1;
            end else begin
                if (arr_S_load) begin
                    sreg_v.push_back(int'(arr_S_valid));
                    sreg_s.push_back(int'(arr_S));
                    if (sreg_v.size() > NUM_PE) begin
                        void'(sreg_v.pop_front());
                        void'(sreg_s.pop_front());
                    end
                    dirty = 1'b1;
                end
                if (arr_ripple_en) begin
                    tq.push_back(int'(arr_T));
                    dirty = 1'b1;
                end
            end
            if (!rst) begin
                mon_sload  += int'(arr_S_load);
                mon_svalid += int'(arr_S_load && arr_S_valid);
                mon_clear  += int'(arr_rst);
                mon_qacc   += int'(q_valid && q_ready);
                mon_tacc   += int'(t_valid && t_ready);
                if (t_valid && t_ready && t_last) mon_tlast_cyc = mon_cyc;
            end
            if ((!arr_ripple_en && arr_T != 2'b00) ||
                (arr_ripple_en != (t_valid && t_ready)) ||
                (arr_ripple_en && arr_T != t_sym) ||
                (arr_S_valid && !(arr_S_load && q_valid && q_ready)) ||
                (arr_S_load && arr_S_valid && arr_S != q_sym) ||
                (q_ready && t_ready) ||
                (arr_max_in != 0) || (arr_V_in != 0) || (arr_V_alpha != 0) || (arr_F_in != 0))
                mon_viol++;
            if (res_valid && !prev_rv) mon_res_cyc = mon_cyc;
            prev_rv = res_valid;
            if (dirty) begin
                qv.delete();
                foreach (sreg_v[k]) if (sreg_v[k] != 0) qv.push_back(sreg_s[k]);
                arr_max_out = 16'(sw_score(qv, tq));
                dirty = 1'b0;
            end
        end
    end

    int qs[0:127];
    int ts[0:255];

    task automatic send_query(input int n);
        int w;
        bit acc;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                q_valid = 1'b0; @(posedge clk); #1;
            end
            q_valid = 1'b1; q_sym = 2'(qs[i]); q_last = (i == n - 1);
            w = 0; acc = 1'b0;
            while (!acc) begin
                @(negedge clk); acc = q_ready;
                @(posedge clk); #1;
                w++;
                if (!acc && w > 300) begin
                    check("q_beat_timeout", 0, 1);
                    q_valid = 1'b0; q_last = 1'b0;
                    return;
                end
            end
        end
        q_valid = 1'b0; q_last = 1'b0;
    endtask

    task automatic send_target(input int n, input int gap_at, input bit do_last);
        int w;
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                t_valid = 1'b0; @(posedge clk); #1;
            end
            t_valid = 1'b1; t_sym = 2'(ts[i]); t_last = do_last && (i == n - 1);
            w = 0; acc = 1'b0;
            while (!acc) begin
                @(negedge clk); acc = t_ready;
                @(posedge clk); #1;
                w++;
                if (!acc && w > 300) begin
                    check("t_beat_timeout", 0, 1);
                    t_valid = 1'b0; t_last = 1'b0;
                    return;
                end
            end
        end
        t_valid = 1'b0; t_last = 1'b0;
    endtask

    task automatic run_job(input string name, input int nq, input int nt, input int gap_at,
                           input int bp, input bit rand_syms, input int fixed_score);
        int qe[$], te[$];
        int s_sload, s_svalid, s_clear, s_viol, s_qacc, s_tacc;
        int exp_score, exp_qlen, exp_err, w, unstable;
        logic [15:0] h_score, h_tlen;
        logic [7:0]  h_qlen;
        logic [1:0]  h_err;
        if (rand_syms) begin
            for (int i = 0; i < nq; i++) qs[i] = int'($urandom_range(3, 0));
            for (int i = 0; i < nt; i++) ts[i] = int'($urandom_range(3, 0));
        end
        for (int i = 0; i < nq && i < NUM_PE; i++) qe.push_back(qs[i]);
        for (int i = 0; i < nt; i++) te.push_back(ts[i]);
        exp_score = sw_score(qe, te);
        exp_qlen  = (nq > NUM_PE) ? NUM_PE : nq;
        exp_err   = (nq > NUM_PE) ? 1 : 0;
`ifdef SW_DRV_TGAP_ERR_EN
        if (gap_at > 0 && gap_at < nt) exp_err += 2;
`endif
        s_sload = mon_sload; s_svalid = mon_svalid; s_clear = mon_clear;
        s_viol = mon_viol; s_qacc = mon_qacc; s_tacc = mon_tacc;

        send_query(nq);
        @(negedge clk);
        check({name, ":q_ready_after_query"}, q_ready, 0);
        @(posedge clk); #1;
        send_target(nt, gap_at, 1'b1);

        w = 0;
        do begin
            @(negedge clk); w++;
        end while (!res_valid && w < 2000);
        check({name, ":res_valid_seen"}, res_valid, 1);
        if (fixed_score >= 0) check({name, ":fixed_score"}, res_score, fixed_score);
        check({name, ":score"}, res_score, exp_score);
        check({name, ":qlen"},  res_qlen,  exp_qlen);
        check({name, ":tlen"},  res_tlen,  nt);
        check({name, ":err"},   res_err,   exp_err);

        h_score = res_score; h_qlen = res_qlen; h_tlen = res_tlen; h_err = res_err;
        unstable = 0;
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); @(negedge clk);
            if (!res_valid || q_ready || t_ready || res_score != h_score || res_qlen != h_qlen ||
                res_tlen != h_tlen || res_err != h_err)
                unstable++;
        end
        check({name, ":result_held"}, unstable, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check({name, ":valid_drop_after_ack"}, res_valid, 0);

        check({name, ":drain_latency"}, mon_res_cyc - mon_tlast_cyc, DRAIN_CYCLES + 1);
        check({name, ":s_load_cycles"}, mon_sload - s_sload, NUM_PE);
        check({name, ":s_valid_cycles"}, mon_svalid - s_svalid, exp_qlen);
        check({name, ":clear_pulses"}, mon_clear - s_clear, 1);
        check({name, ":q_beats_taken"}, mon_qacc - s_qacc, nq);
        check({name, ":t_beats_taken"}, mon_tacc - s_tacc, nt);
        check({name, ":port_rules"}, mon_viol - s_viol, 0);
        @(posedge clk); #1;
    endtask

    task automatic set_acgt();
        for (int i = 0; i < 4; i++) begin
            qs[i] = i;
            ts[i] = i;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        q_valid = 1'b0; q_sym = 2'b00; q_last = 1'b0;
        t_valid = 1'b0; t_sym = 2'b00; t_last = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset:arr_rst", arr_rst, 1);
        check("reset:q_ready", q_ready, 0);
        check("reset:t_ready", t_ready, 0);
        check("reset:res_valid", res_valid, 0);
        check("reset:res_fields", {res_score, res_qlen, res_tlen, res_err}, 0);
        check("reset:arr_S_load", arr_S_load, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle:arr_rst", arr_rst, 0);
        check("idle:q_ready", q_ready, 0);
        @(posedge clk); #1;

        set_acgt();
        run_job("exact", 4, 4, -1, 0, 1'b0, 24);
        run_job("overflow70", 70, 8, -1, 2, 1'b1, -1);
        run_job("full64", 64, 12, -1, 0, 1'b1, -1);
        run_job("single", 1, 5, -1, 0, 1'b1, -1);
        run_job("gap", 10, 10, 5, 0, 1'b1, -1);
        run_job("backpressure", 8, 6, -1, 10, 1'b1, -1);
        for (int r = 0; r < 6; r++) begin
            int nq, nt, gap;
            nq  = int'($urandom_range(80, 1));
            nt  = int'($urandom_range(40, 1));
            gap = ($urandom_range(1, 0) == 1 && nt > 1) ? int'($urandom_range(nt - 1, 1)) : -1;
            run_job($sformatf("rand%0d", r), nq, nt, gap, int'($urandom_range(5, 0)), 1'b1, -1);
        end

        // Abort a job part-way through the target stream.
        set_acgt();
        send_query(4);
        send_target(3, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset:res_valid", res_valid, 0);
        check("midreset:ripple_en", arr_ripple_en, 0);
        check("midreset:arr_rst", arr_rst, 1);
        check("midreset:t_ready", t_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postreset:res_valid", res_valid, 0);
        check("postreset:q_ready", q_ready, 0);
        @(posedge clk); #1;
        set_acgt();
        run_job("after_reset", 4, 4, -1, 0, 1'b0, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
